// File: rtl/pipe_flow_ctrl.sv
// Load enables and valid bits for an N-stage pipeline with stall (freeze or bubble) and targeted flush.
// Load/flush_ack are combinational; valid bits and counters update on the next edge; a refused flush must be held by the requester.
module pipe_flow_ctrl #(
  parameter int NUM_STAGES = 5,
  parameter int STALL_MODE = 1,
  parameter int CNT_W      = 16,
  parameter int SW         = $clog2(NUM_STAGES)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_STAGES-1:0] stall_req,
  input  logic                  if_valid,
  input  logic                  flush_req,
  input  logic [SW-1:0]         flush_stage,
  input  logic                  clear_counters,
  output logic [NUM_STAGES-2:0] load_latch,
  output logic [NUM_STAGES-2:0] valid_out,
  output logic                  flush_ack,
  output logic                  pipe_empty,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic [CNT_W-1:0]      flush_count
);

  localparam int NL = NUM_STAGES - 1;

  logic [NL-1:0]    valid_out_q, valid_out_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0] flush_count_q, flush_count_d;

  logic [NL-1:0] hold_mask;
  logic [NL-1:0] bubble_mask;
  logic [NL-1:0] feed;
  logic [NL-1:0] load;
  logic          any_stall;
  logic          stall_above_fe;
  logic          flush_ok;
  int            fe;

  always_comb begin
    any_stall      = |stall_req;
    fe             = (int'(flush_stage) > NUM_STAGES - 1) ? NUM_STAGES - 1 : int'(flush_stage);
    stall_above_fe = 1'b0;
    hold_mask      = '0;
    bubble_mask    = '0;
    feed           = '0;
    load           = '0;
    flush_ok       = 1'b0;
    valid_out_d    = valid_out_q;

    for (int i = 0; i < NUM_STAGES; i++) begin
      if (stall_req[i] && (i > fe)) stall_above_fe = 1'b1;
    end

    // A latch holds when some stage downstream of it is stalled; the latch
    // directly below the highest stalled stage takes a bubble instead.
    for (int j = 0; j < NL; j++) begin
      for (int i = 0; i < NUM_STAGES; i++) begin
        if (i > j) hold_mask[j] = hold_mask[j] | stall_req[i];
      end
      bubble_mask[j] = stall_req[j] & ~hold_mask[j];
      feed[j]        = (j == 0) ? if_valid : valid_out_q[(j > 0) ? j - 1 : 0];
    end

    if (STALL_MODE == 0) begin
      load     = any_stall ? '0 : '1;
      flush_ok = flush_req & ~any_stall;
    end else begin
      load     = ~hold_mask;
      flush_ok = flush_req & ~stall_above_fe;
    end

    if (reset) begin
      load     = '0;
      flush_ok = 1'b0;
    end

    for (int j = 0; j < NL; j++) begin
      if (load[j]) valid_out_d[j] = bubble_mask[j] ? 1'b0 : feed[j];
      if (flush_ok && (j < fe)) valid_out_d[j] = 1'b0;
    end

    stall_cycles_d = stall_cycles_q;
    flush_count_d  = flush_count_q;
    if (any_stall && (stall_cycles_q != '1)) stall_cycles_d = stall_cycles_q + CNT_W'(1);
    if (flush_ok && (flush_count_q != '1))   flush_count_d  = flush_count_q + CNT_W'(1);
    if (clear_counters) begin
      stall_cycles_d = '0;
      flush_count_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_out_q    <= '0;
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      valid_out_q    <= valid_out_d;
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign load_latch   = load;
  assign valid_out    = valid_out_q;
  assign flush_ack    = flush_ok;
  assign pipe_empty   = ~|valid_out_q;
  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;

endmodule

// File: doc/pipe_flow_ctrl.md
Name: pipe_flow_ctrl

Overview:
- Parametrised pipeline flow controller, successor to the fixed 5-stage stall logic in the LC-3b core.
- Generates per-latch load enables and valid bits for an N-stage pipeline.
- Handles per-stage stall requests in two modes: global freeze, or bubble insertion.
- Adds stage-targeted flush for branch squash, plus saturating stall/flush performance counters. Sits beside the stage latches in cpu_datapath.

Parameters:
NUM_STAGES, 5, pipeline stages (IF=0 … WB=N-1); latches = NUM_STAGES-1, latch j sits between stage j and j+1
STALL_MODE, 1, 0 = any stall freezes every latch; 1 = bubble insertion below highest stalled stage
CNT_W, 16, width of performance counters
SW, $clog2(NUM_STAGES), width of flush_stage (derived, not overridden)

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
stall_req  input  NUM_STAGES  bit k = stage k cannot complete this cycle (e.g. bit0 icache miss, bit3 dcache miss/indirect)
if_valid  input  1  fetch stage presents a real instruction
flush_req  input  1  squash request from resolving stage
flush_stage  input  SW  index f of resolving stage
clear_counters  input  1  synchronous counter clear
load_latch  output  NUM_STAGES-1  combinational load enable per latch
valid_out  output  NUM_STAGES-1  registered valid bit carried with each latch
flush_ack  output  1  combinational; flush taken this cycle
pipe_empty  output  1  ~|valid_out
stall_cycles  output  CNT_W  cycles with any stall_req bit set, saturating
flush_count  output  CNT_W  accepted flushes, saturating

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, on the port named reset.
- Reset state: valid_out=0, stall_cycles=0, flush_count=0.
- While reset is high: load_latch=0 and flush_ack=0, regardless of inputs.
- Definitions:
  - k = highest index with stall_req[k]=1, or -1 if none.
  - feed(j) = if_valid for j=0, else valid_out[j-1].
  - fe = min(flush_stage, NUM_STAGES-1).
- STALL_MODE=1 (bubble insertion):
  - j<k: load_latch[j]=0, valid holds.
  - j==k: load_latch[j]=1, valid_out[j]←0 (bubble).
  - j>k: load_latch[j]=1, valid_out[j]←feed(j).
  - k=NUM_STAGES-1: all latches hold; no bubble.
- STALL_MODE=0 (global freeze):
  - k≥0: load_latch=0 and all valid bits hold.
  - k=-1: all load=1, valid_out[j]←feed(j).
- Flush acceptance (flush_ack=1):
  - Mode 1: flush_req && k≤fe.
  - Mode 0: flush_req && k==-1.
  - Otherwise flush_ack=0 and the requester must hold flush_req. No internal queueing.
- On an accepted flush:
  - Latches j<fe: valid_out[j]←0 at the edge, overriding the stall rules for those latches. load_latch for them follows the stall rules (data is don't-care).
  - Latches j≥fe: follow the normal stall rules. The resolving instruction proceeds.
- fe=0: no latch is invalidated, but flush_ack=1 and flush_count still increments.
- Counters:
  - stall_cycles += 1 each non-reset cycle with |stall_req.
  - flush_count += 1 on flush_ack.
  - Both saturate at all-ones and never wrap.
  - clear_counters zeroes both at the edge and wins over a simultaneous increment.
- No state machine beyond the valid registers. Latency: load/ack combinational; valid and counters update at the next rising edge.
- Reset mid-stall or mid-flush: all state cleared on that edge; pending requests are not remembered.

Test Plan:
(N=5, CNT_W=16; valid_out written bit3..bit0)
1. Reset, then if_valid=1, no stalls, 4 cycles -> valid_out 0001, 0011, 0111, 1111; load_latch=1111 every cycle; pipe_empty falls after first edge.
2. Mode 1, valid_out=1111, stall_req=01000 for 3 cycles -> load_latch=1000 and valid_out=0111 after first edge, held thereafter; stall_cycles=3. Then stall_req=00001 -> load_latch=1111, latch0 gets a bubble (valid_out[0]←0).
3. Mode 0, same stall -> load_latch=0000 for 3 cycles, valid_out stays 1111, stall_cycles=3.
4. flush_req=1, flush_stage=4, no stall -> flush_ack=1 same cycle; valid_out=0000 next edge; flush_count=1. flush_stage=7 behaves identically (clamped).
5. Mode 1, flush_stage=2, stall_req=01000 for 2 cycles -> flush_ack=0 both cycles. Stall drops -> flush_ack=1; valid_out[1:0]=00; valid_out[3:2] loaded normally.
6. CNT_W=4 build: 20 stall cycles -> stall_cycles=15 (saturated). Then clear_counters=1 with stall_req≠0 -> 0 next edge. Reset asserted with flush_req=1 -> flush_ack=0, counters 0.
